// File: rtl/seq_pkg.sv
// Shared constants for the program sequencer: control-flow opcodes, HALT encoding, FSM states.
package seq_pkg;

  localparam logic [3:0]  OP_BEQ     = 4'b1000;
  localparam logic [3:0]  OP_BNE     = 4'b1001;
  localparam logic [3:0]  OP_BGEZ    = 4'b1010;
  localparam logic [3:0]  OP_BLTZ    = 4'b1011;

  localparam logic [15:0] INSTR_HALT = 16'h0001;

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_RUN     = 2'd1;
  localparam logic [1:0]  ST_STEP    = 2'd2;
  localparam logic [1:0]  ST_HALT    = 2'd3;

endpackage

// File: rtl/pc_next.sv
// Branch resolution and next-PC computation for the fetched instruction (purely combinational).
module pc_next
  import seq_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IW   = 16
) (
  input  logic [PC_W-1:0] PC,
  input  logic [IW-1:0]   INSTR,
  input  logic            RS_EQ_RT,
  input  logic            RS_NEG,
  output logic [PC_W-1:0] NEXT_PC,
  output logic            BR_TAKEN
);

  logic [3:0]      op;
  logic [PC_W-1:0] pc_plus2;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] sum;
  logic            unused_bits;

  assign op          = INSTR[15:12];
  assign unused_bits = ^INSTR[11:6];

  always_comb begin
    BR_TAKEN = 1'b0;
    case (op)
      OP_BEQ:  BR_TAKEN = RS_EQ_RT;
      OP_BNE:  BR_TAKEN = !RS_EQ_RT;
      OP_BGEZ: BR_TAKEN = !RS_NEG;
      OP_BLTZ: BR_TAKEN = RS_NEG;
      default: BR_TAKEN = 1'b0;
    endcase
  end

  // Sign-extended imm6 scaled to a byte offset (<< 1); sums wrap modulo 2^PC_W.
  assign offset   = {{(PC_W-6){INSTR[5]}}, INSTR[4:0], 1'b0};
  assign pc_plus2 = PC + PC_W'(2);
  assign sum      = pc_plus2 + (BR_TAKEN ? offset : '0);
  assign NEXT_PC  = sum & {{(PC_W-1){1'b1}}, 1'b0};

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: PC register, run/step/halt FSM, COMMIT gating.
// Optional retired-instruction counter enabled by `define PC_SEQ_RETIRE_CNT_EN.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(8'h00)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [IW-1:0]   INSTR,
  input  logic            RS_EQ_RT,
  input  logic            RS_NEG,
  input  logic            START,
  input  logic            PAUSE,
  input  logic            STEP,
  output logic [PC_W-1:0] PC,
  output logic            COMMIT,
  output logic            BR_TAKEN,
  output logic            HALTED,
  output logic [1:0]      STATE
`ifdef PC_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]     RETIRED
`endif
);

  logic [1:0]      state_d;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] next_pc;
  logic            taken;
  logic            step_q;
  logic            step_edge;
  logic            is_halt;

  pc_next #(
    .PC_W (PC_W),
    .IW   (IW)
  ) u_pc_next (
    .PC       (PC),
    .INSTR    (INSTR),
    .RS_EQ_RT (RS_EQ_RT),
    .RS_NEG   (RS_NEG),
    .NEXT_PC  (next_pc),
    .BR_TAKEN (taken)
  );

  assign is_halt   = (INSTR == IW'(INSTR_HALT));
  assign step_edge = STEP & ~step_q;

  // Nothing commits while reset is asserted, whatever state the FSM is in.
  assign COMMIT   = !RESET && ((STATE == ST_RUN) || (STATE == ST_STEP)) && !is_halt;
  assign BR_TAKEN = COMMIT && taken;

  // Next-state and next-PC selection.
  always_comb begin
    state_d = STATE;
    pc_d    = PC;
    case (STATE)
      ST_IDLE: begin
        if (START)          state_d = ST_RUN;
        else if (step_edge) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d = next_pc;
          if (PAUSE) state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = next_pc;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC     <= {RESET_PC[PC_W-1:1], 1'b0};
      STATE  <= ST_IDLE;
      HALTED <= 1'b0;
      step_q <= 1'b0;
    end else begin
      PC     <= pc_d;
      STATE  <= state_d;
      HALTED <= (state_d == ST_HALT);
      step_q <= STEP;
    end
  end

`ifdef PC_SEQ_RETIRE_CNT_EN
  // Saturating count of committed instructions.
  always_ff @(posedge CLK) begin
    if (RESET)                        RETIRED <= 16'h0000;
    else if (COMMIT && RETIRED != '1) RETIRED <= RETIRED + 16'd1;
  end
`endif

endmodule
